izigzag_buf: RTL and testbench

- Decoder-side inverse zigzag reorder buffer for the JPEG pipeline.
- Accepts one 8x8 block of 64 coefficients as a byte stream in zigzag scan order, then emits the same 64 values in raster (row-major) order.
- Is the read-side counterpart of the encoder's zigzag stage.
- Feeds the IDCT path; valid/ready handshake on both sides.

---
 rtl/izz_pkg.sv | 30 +++
 rtl/izz_bank.sv | 36 +++
 rtl/izigzag_buf.sv | 178 +++++++++++++++++
 tb/tb_izigzag_buf.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/izz_pkg.sv
// ----------------------------------------------------------------------------
// izz_pkg
// Shared definitions for the inverse zigzag reorder buffer.
//   DATA_W_DFLT : default coefficient width
//   BLK_N       : coefficients per 8x8 block (fixed at 64)
//   izz_state_e : FILL / DRAIN state encoding
//   ZZ          : zigzag scan index -> raster (row-major) index
// ----------------------------------------------------------------------------
package izz_pkg;

    localparam int DATA_W_DFLT = 8;
    localparam int BLK_N       = 64;

    typedef enum logic {
        FILL  = 1'b0,
        DRAIN = 1'b1
    } izz_state_e;

    localparam logic [5:0] ZZ [BLK_N] = '{
         0,  1,  8, 16,  9,  2,  3, 10,
        17, 24, 32, 25, 18, 11,  4,  5,
        12, 19, 26, 33, 40, 48, 41, 34,
        27, 20, 13,  6,  7, 14, 21, 28,
        35, 42, 49, 56, 57, 50, 43, 36,
        29, 22, 15, 23, 30, 37, 44, 51,
        58, 59, 52, 45, 38, 31, 39, 46,
        53, 60, 61, 54, 47, 55, 62, 63
    };

endpackage

// File: rtl/izz_bank.sv
// ----------------------------------------------------------------------------
// izz_bank
// 64-entry coefficient store: one synchronous write port, one asynchronous
// read port. Contents are not reset; a block is always fully written before
// it is read.
//   clk     : rising-edge clock
//   wr_en   : write enable
//   wr_addr : raster address to write
//   wr_data : coefficient to write
//   rd_addr : raster address to read
//   rd_data : coefficient at rd_addr (combinational)
// ----------------------------------------------------------------------------
module izz_bank
    import izz_pkg::*;
#(
    parameter int DATA_W = DATA_W_DFLT
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [5:0]        wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [5:0]        rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] mem_q [BLK_N];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem_q[rd_addr];

endmodule

// File: rtl/izigzag_buf.sv
// ----------------------------------------------------------------------------
// izigzag_buf
// Inverse zigzag reorder buffer: accepts 64 coefficients of an 8x8 block in
// zigzag scan order and emits them in raster order. Writes are scattered
// through the ZZ table, reads are sequential.
//   clk, rst            : clock, synchronous active-high reset
//   in_data/valid/ready : zigzag-order input stream
//   out_data/valid/ready: raster-order output stream
//   out_last            : marks raster index 63
// Build option: IZZ_PINGPONG_EN selects two banks so one block can fill while
// the previous one drains; default is a single bank alternating FILL/DRAIN.
//
// state | meaning
// ------+-----------------------------------------------
// FILL  | accepting zigzag input, in_ready=1
// DRAIN | emitting raster output, out_valid=1
// (ping-pong build replaces the FSM with per-bank full flags)
// ----------------------------------------------------------------------------
module izigzag_buf
    import izz_pkg::*;
#(
    parameter int DATA_W = DATA_W_DFLT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_last
);

    logic [5:0]        wr_cnt_q, wr_cnt_d;
    logic [5:0]        rd_cnt_q, rd_cnt_d;
    // Registered so in_ready stays low while rst is held and rises one
    // cycle after release.
    logic              in_ready_q, in_ready_d;
    logic              in_xfer, out_xfer;
    logic [DATA_W-1:0] rd_data;

    assign in_ready = in_ready_q;
    assign in_xfer  = in_valid & in_ready_q;
    assign out_xfer = out_valid & out_ready;

`ifdef IZZ_PINGPONG_EN

    logic [1:0]        full_q, full_d;
    logic              wb_q, wb_d;
    logic              rb_q, rb_d;
    logic [DATA_W-1:0] rd_data0, rd_data1;

    always_comb begin
        wr_cnt_d = wr_cnt_q;
        rd_cnt_d = rd_cnt_q;
        full_d   = full_q;
        wb_d     = wb_q;
        rb_d     = rb_q;
        if (in_xfer) begin
            wr_cnt_d = wr_cnt_q + 6'd1;
            if (wr_cnt_q == 6'd63) begin
                full_d[wb_q] = 1'b1;
                wb_d         = ~wb_q;
            end
        end
        // When both complete on one edge wb != rb, so the two updates never
        // touch the same flag.
        if (out_xfer) begin
            rd_cnt_d = rd_cnt_q + 6'd1;
            if (rd_cnt_q == 6'd63) begin
                full_d[rb_q] = 1'b0;
                rb_d         = ~rb_q;
            end
        end
        in_ready_d = ~full_d[wb_d];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_cnt_q   <= '0;
            rd_cnt_q   <= '0;
            in_ready_q <= 1'b0;
            full_q     <= '0;
            wb_q       <= 1'b0;
            rb_q       <= 1'b0;
        end else begin
            wr_cnt_q   <= wr_cnt_d;
            rd_cnt_q   <= rd_cnt_d;
            in_ready_q <= in_ready_d;
            full_q     <= full_d;
            wb_q       <= wb_d;
            rb_q       <= rb_d;
        end
    end

    izz_bank #(.DATA_W(DATA_W)) u_bank0 (
        .clk     (clk),
        .wr_en   (in_xfer & ~wb_q),
        .wr_addr (ZZ[wr_cnt_q]),
        .wr_data (in_data),
        .rd_addr (rd_cnt_q),
        .rd_data (rd_data0)
    );

    izz_bank #(.DATA_W(DATA_W)) u_bank1 (
        .clk     (clk),
        .wr_en   (in_xfer & wb_q),
        .wr_addr (ZZ[wr_cnt_q]),
        .wr_data (in_data),
        .rd_addr (rd_cnt_q),
        .rd_data (rd_data1)
    );

    assign out_valid = full_q[rb_q];
    assign rd_data   = rb_q ? rd_data1 : rd_data0;

`else

    izz_state_e state_q, state_d;

    always_comb begin
        state_d  = state_q;
        wr_cnt_d = wr_cnt_q;
        rd_cnt_d = rd_cnt_q;
        case (state_q)
            FILL: begin
                if (in_xfer) begin
                    wr_cnt_d = wr_cnt_q + 6'd1;
                    if (wr_cnt_q == 6'd63) begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (out_xfer) begin
                    rd_cnt_d = rd_cnt_q + 6'd1;
                    if (rd_cnt_q == 6'd63) begin
                        state_d = FILL;
                    end
                end
            end
            default: state_d = FILL;
        endcase
        in_ready_d = (state_d == FILL);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= FILL;
            wr_cnt_q   <= '0;
            rd_cnt_q   <= '0;
            in_ready_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            wr_cnt_q   <= wr_cnt_d;
            rd_cnt_q   <= rd_cnt_d;
            in_ready_q <= in_ready_d;
        end
    end

    izz_bank #(.DATA_W(DATA_W)) u_bank0 (
        .clk     (clk),
        .wr_en   (in_xfer),
        .wr_addr (ZZ[wr_cnt_q]),
        .wr_data (in_data),
        .rd_addr (rd_cnt_q),
        .rd_data (rd_data)
    );

    assign out_valid = (state_q == DRAIN);

`endif

    assign out_data = out_valid ? rd_data : '0;
    assign out_last = out_valid & (rd_cnt_q == 6'd63);

endmodule

// File: tb/tb_izigzag_buf.sv
module tb_izigzag_buf;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] in_data = 8'h00;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready = 1'b1;
    logic       out_last;

    int n_checks = 0;
    int n_errors = 0;

    logic [5:0] inv [64];   // raster index -> zigzag index, built by walking diagonals
    logic [7:0] got [64];

`ifdef IZZ_PINGPONG_EN
    localparam bit PP = 1'b1;
`else
    localparam bit PP = 1'b0;
`endif

    always #5 clk = ~clk;

    izigzag_buf #(.DATA_W(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_last  (out_last)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic build_inv;
        int idx = 0;
        for (int s = 0; s < 15; s++) begin
            int lo = (s > 7) ? s - 7 : 0;
            int hi = (s < 7) ? s : 7;
            if (s % 2 == 1) begin
                for (int row = lo; row <= hi; row++) begin
                    inv[row*8 + (s-row)] = 6'(idx);
                    idx++;
                end
            end else begin
                for (int row = hi; row >= lo; row--) begin
                    inv[row*8 + (s-row)] = 6'(idx);
                    idx++;
                end
            end
        end
    endtask

    task automatic send_n(input int n, input bit use_fixed, input logic [7:0] fixed,
                          input logic [1:0] blk, input bit gaps, input bit chk_nov,
                          input bit chk_rdy);
        int  sent = 0;
        int  cyc  = 0;
        bit  x;
        while (sent < n && cyc < 400) begin
            in_valid = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
            in_data  = use_fixed ? fixed : {blk, 6'(sent)};
            if (chk_nov) chk("fill_no_valid", 32'(out_valid), 32'd0);
            if (chk_rdy) chk("pp_in_ready", 32'(in_ready), 32'd1);
            x = in_valid && in_ready;
            step;
            cyc++;
            if (x) sent++;
        end
        in_valid = 1'b0;
        if (sent < n) chk("send_timeout", 32'(sent), 32'(n));
    endtask

    task automatic recv_n(input int n, input bit use_fixed, input logic [7:0] fixed,
                          input int sa, input int sb, input bit chk_nordy, input bit jam);
        int         r = 0;
        int         cyc = 0;
        int         lasts = 0;
        bit         done_a = 0;
        bit         done_b = 0;
        logic [7:0] held;
        logic [7:0] exp;
        out_ready = 1'b1;
        if (jam) begin
            in_valid = 1'b1;
            in_data  = 8'hFF;
        end
        while (r < n && cyc < 800) begin
            if (chk_nordy) chk("drain_in_ready", 32'(in_ready), 32'd0);
            if (out_valid) begin
                if ((r % 64 == sa && !done_a) || (r % 64 == sb && !done_b)) begin
                    if (r % 64 == sa) done_a = 1; else done_b = 1;
                    out_ready = 1'b0;
                    held = out_data;
                    repeat (5) begin
                        step;
                        cyc++;
                        chk("bp_hold_data", 32'(out_data), 32'(held));
                        chk("bp_hold_valid", 32'(out_valid), 32'd1);
                    end
                    out_ready = 1'b1;
                end
                exp = use_fixed ? fixed : {2'(r / 64), inv[r % 64]};
                chk($sformatf("data_r%0d", r % 64), 32'(out_data), 32'(exp));
                chk($sformatf("last_r%0d", r % 64), 32'(out_last), 32'(r % 64 == 63));
                if (out_last) lasts++;
                got[r % 64] = out_data;
                r++;
            end else begin
                chk("idle_data_zero", 32'(out_data), 32'd0);
            end
            step;
            cyc++;
        end
        if (jam) in_valid = 1'b0;
        if (r < n) chk("recv_timeout", 32'(r), 32'(n));
        chk("last_count", 32'(lasts), 32'(n / 64));
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        build_inv();

        // reset held 3 cycles with in_valid asserted
        rst = 1'b1;
        in_valid = 1'b1;
        in_data = 8'h33;
        repeat (3) begin
            step;
            chk("rst_in_ready", 32'(in_ready), 32'd0);
            chk("rst_out_valid", 32'(out_valid), 32'd0);
            chk("rst_out_data", 32'(out_data), 32'd0);
        end
        rst = 1'b0;
        in_valid = 1'b0;
        step;
        chk("rdy_after_rst", 32'(in_ready), 32'd1);

        // ordering, contiguous
        send_n(64, 1'b0, 8'h00, 2'd0, 1'b0, 1'b1, 1'b0);
        chk("latency_valid", 32'(out_valid), 32'd1);
        if (!PP) chk("no_65th_accept", 32'(in_ready), 32'd0);
        recv_n(64, 1'b0, 8'h00, -1, -1, !PP, 1'b0);
        chk("rast0", 32'(got[0]), 32'd0);
        chk("rast1", 32'(got[1]), 32'd1);
        chk("rast2", 32'(got[2]), 32'd5);
        chk("rast3", 32'(got[3]), 32'd6);
        chk("rast4", 32'(got[4]), 32'd14);
        chk("rast5", 32'(got[5]), 32'd15);
        chk("rast8", 32'(got[8]), 32'd2);
        chk("rast63", 32'(got[63]), 32'd63);
        chk("post_drain_valid", 32'(out_valid), 32'd0);

        // backpressure at raster 10 and 40, with in_valid jammed high during drain
        send_n(64, 1'b0, 8'h00, 2'd0, 1'b0, 1'b0, 1'b0);
        recv_n(64, 1'b0, 8'h00, 10, 40, !PP, !PP);

        // random input gaps
        send_n(64, 1'b0, 8'h00, 2'd0, 1'b1, 1'b0, 1'b0);
        recv_n(64, 1'b0, 8'h00, -1, -1, !PP, 1'b0);

        // mid-block reset discards the partial block
        send_n(20, 1'b0, 8'h00, 2'd0, 1'b0, 1'b0, 1'b0);
        rst = 1'b1;
        step;
        chk("midrst_in_ready", 32'(in_ready), 32'd0);
        rst = 1'b0;
        step;
        chk("midrst_rdy_after", 32'(in_ready), 32'd1);
        send_n(64, 1'b1, 8'hA5, 2'd0, 1'b0, 1'b0, 1'b0);
        recv_n(64, 1'b1, 8'hA5, -1, -1, !PP, 1'b0);

`ifdef IZZ_PINGPONG_EN
        // four back-to-back blocks, fill and drain overlapped
        fork
            begin
                for (int b = 0; b < 4; b++) begin
                    send_n(64, 1'b0, 8'h00, 2'(b), 1'b0, 1'b0, (b > 0));
                end
            end
            recv_n(256, 1'b0, 8'h00, -1, -1, 1'b0, 1'b0);
        join
        chk("pp_post_valid", 32'(out_valid), 32'd0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
